// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: sequences the UART RX counter, sampler, deserializer and start/parity/stop checkers across one frame.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_count,
    input  logic [BIT_CNT_W-1:0]  bit_count,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  cnt_enable,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error
);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] WD_LIM    = BIT_CNT_W'(DATA_WIDTH + 3);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;
    logic err_latch, err_nxt, par_q, dv_nxt, pe_nxt, fe_nxt;
    logic [PRESCALE_W-1:0] chk;
    logic at_chk, at_end, at_exit;
    // chk is the edge where the 3-sample majority vote is settled
    assign chk     = (prescale >> 1) + PRESCALE_W'(2);
    assign at_chk  = edge_count == chk;
    assign at_end  = edge_count == prescale;
    assign at_exit = edge_count == chk + PRESCALE_W'(1);
    assign cnt_enable  = state != IDLE;
    assign dat_samp_en = state != IDLE;
    assign strt_chk_en = state == START && at_chk;
    assign deser_en    = state == DATA && at_chk;
    assign par_chk_en  = state == PARITY && at_chk;
    assign stp_chk_en  = state == STOP && at_chk;
    always_comb begin
        state_nxt = state;
        err_nxt   = err_latch;
        dv_nxt    = 1'b0;
        pe_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        if (state != IDLE && bit_count > WD_LIM) begin
            state_nxt = IDLE;
            fe_nxt    = 1'b1;
        end else begin
            case (state)
                IDLE: if (!RX_IN) begin
                    state_nxt = START;
                    err_nxt   = 1'b0;
                end
                START: state_nxt = (at_chk && strt_glitch) ? IDLE : at_end ? DATA : START;
                DATA: if (at_end && bit_count == LAST_DATA) state_nxt = par_q ? PARITY : STOP;
                PARITY: begin
                    if (at_chk && par_err) begin
                        err_nxt = 1'b1;
                        pe_nxt  = 1'b1;
                    end
                    if (at_end) state_nxt = STOP;
                end
                // leaving mid stop bit lets the next start bit be caught on time
                STOP: if (at_exit) begin
                    state_nxt = IDLE;
                    dv_nxt    = !stp_err && !err_latch;
                    fe_nxt    = stp_err;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            err_latch     <= 1'b0;
            par_q         <= 1'b0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_nxt;
            err_latch     <= err_nxt;
            par_q         <= (state == IDLE) ? PAR_EN : par_q;
            data_valid    <= dv_nxt;
            parity_error  <= pe_nxt;
            framing_error <= fe_nxt;
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: drives serial frames through uart_rx_fsm with a stub counter and scoreboards received bytes.
module tb_uart_rx_fsm;
    logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0;
    logic strt_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
    logic [5:0] prescale = 6'd8, edge_count;
    logic [3:0] bit_count;
    logic cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic data_valid, parity_error, framing_error;
    int vectors = 0, miscompares = 0;
    int cyc = 0, start_cyc = 0, lat = 0;
    int n_dv = 0, n_pe = 0, n_fe = 0, n_deser = 0, n_par = 0, par_edge = 0, par_bit = 0;
    logic prev_cnt = 1'b0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    uart_rx_fsm dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
        .edge_count(edge_count), .bit_count(bit_count), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .cnt_enable(cnt_enable),
        .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .parity_error(parity_error), .framing_error(framing_error)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST || !cnt_enable) begin
            edge_count <= 6'd1;
            bit_count  <= 4'd1;
        end else if (edge_count == prescale) begin
            edge_count <= 6'd1;
            bit_count  <= bit_count + 4'd1;
        end else
            edge_count <= edge_count + 6'd1;
    end

    task automatic tick();
        logic [7:0] e;
        @(negedge CLK);
        cyc++;
        if (cnt_enable && !prev_cnt) start_cyc = cyc;
        prev_cnt = cnt_enable;
        if (deser_en) begin
            n_deser++;
            shreg = {RX_IN, shreg[7:1]};
            vectors++;
            if (int'(edge_count) !== int'(prescale) / 2 + 2) begin
                miscompares++;
                $display("FAIL deser_edge: got edge %0d want %0d", edge_count, int'(prescale) / 2 + 2);
            end
        end
        if (par_chk_en) begin
            n_par++;
            par_edge = edge_count;
            par_bit  = bit_count;
        end
        if (parity_error) n_pe++;
        if (framing_error) n_fe++;
        if (data_valid) begin
            n_dv++;
            lat = cyc - start_cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL dv_unexpected: data %h received, none expected", shreg);
            end else begin
                e = exp_q.pop_front();
                if (shreg !== e) begin
                    miscompares++;
                    $display("FAIL rx_data: got %h want %h", shreg, e);
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit good);
        int k;
        if (good) exp_q.push_back(d);
        RX_IN = 1'b0;
        repeat (prescale) tick();
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (prescale) tick();
        end
        if (PAR_EN) begin
            RX_IN = ^d;
            repeat (prescale) tick();
        end
        RX_IN = 1'b1;
        k = 0;
        while (cnt_enable !== 1'b0 && k < 4 * int'(prescale)) begin
            tick();
            k++;
        end
        vectors++;
        if (cnt_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_end: cnt_enable %b after %0d cycles, want 0", cnt_enable, k);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        RX_IN = 1'b0;
        tick();
        tick();
        vectors++;
        if ({cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
             data_valid, parity_error, framing_error} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 000000000", {cnt_enable, dat_samp_en,
                     deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, parity_error, framing_error});
        end
        RX_IN = 1'b1;
        RST = 1'b1;
        repeat (3) tick();
        chk_int("idle_cnt_enable", int'(cnt_enable), 0);
    endtask

    task automatic test_no_parity();
        int dv0 = n_dv, pe0 = n_pe, fe0 = n_fe, ds0 = n_deser;
        prescale = 6'd8;
        PAR_EN = 1'b0;
        send_frame(8'hA5, 1'b1);
        chk_int("np_deser_count", n_deser - ds0, 8);
        chk_int("np_dv_count", n_dv - dv0, 1);
        chk_int("np_latency", lat, 79);
        chk_int("np_err_pulses", (n_pe - pe0) + (n_fe - fe0), 0);
        chk_int("np_queue", exp_q.size(), 0);
    endtask

    task automatic test_parity_good();
        int dv0 = n_dv, pe0 = n_pe, pc0 = n_par;
        prescale = 6'd16;
        PAR_EN = 1'b1;
        send_frame(8'h3C, 1'b1);
        chk_int("pg_parchk_count", n_par - pc0, 1);
        chk_int("pg_parchk_edge", par_edge, 10);
        chk_int("pg_parchk_bit", par_bit, 10);
        chk_int("pg_dv_count", n_dv - dv0, 1);
        chk_int("pg_parity_error", n_pe - pe0, 0);
        chk_int("pg_latency", lat, 171);
    endtask

    task automatic test_parity_err();
        int dv0 = n_dv, pe0 = n_pe, fe0 = n_fe;
        prescale = 6'd8;
        PAR_EN = 1'b1;
        par_err = 1'b1;
        send_frame(8'h5A, 1'b0);
        par_err = 1'b0;
        chk_int("pe_pulse_cycles", n_pe - pe0, 1);
        chk_int("pe_dv_count", n_dv - dv0, 0);
        chk_int("pe_framing", n_fe - fe0, 0);
        dv0 = n_dv;
        send_frame(8'hC3, 1'b1);
        chk_int("pe_next_dv", n_dv - dv0, 1);
        chk_int("pe_next_latency", lat, 87);
    endtask

    task automatic test_glitch();
        int dv0 = n_dv, pe0 = n_pe, fe0 = n_fe, k = 0;
        prescale = 6'd8;
        PAR_EN = 1'b0;
        strt_glitch = 1'b1;
        RX_IN = 1'b0;
        tick();
        tick();
        RX_IN = 1'b1;
        while (strt_chk_en !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk_int("gl_strt_edge", int'(edge_count), 6);
        tick();
        chk_int("gl_cnt_enable", int'(cnt_enable), 0);
        repeat (10) tick();
        strt_glitch = 1'b0;
        chk_int("gl_no_pulses", (n_dv - dv0) + (n_pe - pe0) + (n_fe - fe0), 0);
        send_frame(8'h81, 1'b1);
        chk_int("gl_next_dv", n_dv - dv0, 1);
    endtask

    task automatic test_framing();
        int dv0 = n_dv, fe0 = n_fe;
        prescale = 6'd8;
        PAR_EN = 1'b0;
        stp_err = 1'b1;
        send_frame(8'hFF, 1'b0);
        stp_err = 1'b0;
        chk_int("fe_pulse", n_fe - fe0, 1);
        chk_int("fe_dv_count", n_dv - dv0, 0);
    endtask

    task automatic test_back_to_back();
        int dv0 = n_dv, fe0 = n_fe;
        prescale = 6'd8;
        PAR_EN = 1'b0;
        send_frame(8'h12, 1'b1);
        send_frame(8'hED, 1'b1);
        chk_int("b2b_dv_count", n_dv - dv0, 2);
        chk_int("b2b_framing", n_fe - fe0, 0);
        chk_int("b2b_queue", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid();
        int dv0, pe0, fe0, k = 0;
        prescale = 6'd8;
        PAR_EN = 1'b0;
        RX_IN = 1'b0;
        while (bit_count !== 4'd5 && k < 200) begin
            tick();
            k++;
        end
        chk_int("rm_reach_bit5", int'(bit_count), 5);
        dv0 = n_dv; pe0 = n_pe; fe0 = n_fe;
        RST = 1'b0;
        #1;
        vectors++;
        if ({cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
             data_valid, parity_error, framing_error} !== 9'b0) begin
            miscompares++;
            $display("FAIL rm_async_outputs: got %b want 000000000", {cnt_enable, dat_samp_en,
                     deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, parity_error, framing_error});
        end
        tick();
        RX_IN = 1'b1;
        tick();
        RST = 1'b1;
        repeat (4) tick();
        chk_int("rm_idle_after", int'(cnt_enable), 0);
        chk_int("rm_no_pulses", (n_dv - dv0) + (n_pe - pe0) + (n_fe - fe0), 0);
        send_frame(8'h96, 1'b1);
        chk_int("rm_next_dv", n_dv - dv0, 1);
        chk_int("rm_queue", exp_q.size(), 0);
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity_good();
        test_parity_err();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 1000000");
        $fatal(1, "timeout");
    end
endmodule
